// File: rtl/bpu_pkg.sv
// Shared types for the branch prediction unit: counter encodings and
// the BTB entry layout used by the lookup and update paths.
package bpu_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  localparam ctr_e CTR_ALLOC = WT;
  localparam ctr_e CTR_RESET = WNT;

  // Smallest legal table (4 entries) leaves 28 tag bits; narrower tags zero-extend.
  localparam int TAG_W_MAX = 28;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [31:0]          target;
    ctr_e                 ctr;
  } btb_entry_t;

  function automatic logic [TAG_W_MAX-1:0] tagOf(input logic [31:0] pc,
                                                 input int unsigned idxW);
    return TAG_W_MAX'(pc >> (idxW + 2));
  endfunction

endpackage

// File: rtl/bpu_sat_ctr.sv
// Next-state logic for a 2-bit saturating direction counter.
module bpu_sat_ctr
  import bpu_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_next_o
);

  always_comb begin
    ctr_next_o = ctr_i;
    case (ctr_e'(ctr_i))
      SNT: ctr_next_o = taken_i ? WNT : SNT;
      WNT: ctr_next_o = taken_i ? WT  : SNT;
      WT:  ctr_next_o = taken_i ? ST  : WNT;
      ST:  ctr_next_o = taken_i ? ST  : WT;
      default: ctr_next_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency lookup on the
// fetch PC, trained by resolved branches from execute.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc_i,
  output logic        bpu_branch,
  output logic [31:0] bpu_addr,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        flush_i,
  output logic [31:0] mispredict_cnt
);

  btb_entry_t btb_q [ENTRIES];
  btb_entry_t btb_d [ENTRIES];
  logic [31:0] mispredictCnt_q;
  logic [31:0] mispredictCnt_d;

  logic [IDX_W-1:0]     lookupIdx;
  logic [TAG_W_MAX-1:0] lookupTag;
  btb_entry_t           lookupEntry;
  logic                 lookupHit;

  logic [IDX_W-1:0]     updIdx;
  logic [TAG_W_MAX-1:0] updTag;
  btb_entry_t           updEntry;
  logic                 updHit;
  logic                 updOldPred;
  logic                 updMispredict;
  logic [1:0]           ctrNext;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_i[1:0], upd_pc[1:0]};

  assign lookupIdx   = pc_i[IDX_W+1:2];
  assign lookupTag   = tagOf(pc_i, IDX_W);
  assign lookupEntry = btb_q[lookupIdx];
  assign lookupHit   = lookupEntry.valid && (lookupEntry.tag == lookupTag);

  // Lookup reads the registered table, so a same-cycle update is not yet visible.
  assign bpu_branch = lookupHit && lookupEntry.ctr[1];
  assign bpu_addr   = lookupHit ? lookupEntry.target : 32'h0;

  assign updIdx        = upd_pc[IDX_W+1:2];
  assign updTag        = tagOf(upd_pc, IDX_W);
  assign updEntry      = btb_q[updIdx];
  assign updHit        = updEntry.valid && (updEntry.tag == updTag);
  assign updOldPred    = updHit && updEntry.ctr[1];
  assign updMispredict = upd_valid && (updOldPred != upd_taken);

  bpu_sat_ctr u_sat_ctr (
    .ctr_i      (updEntry.ctr),
    .taken_i    (upd_taken),
    .ctr_next_o (ctrNext)
  );

  // Flush takes priority over training; it only drops valid bits so counters
  // and targets survive for a later re-allocation.
  always_comb begin
    btb_d = btb_q;
    if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_d[i].valid = 1'b0;
      end
    end else if (upd_valid) begin
      if (updHit) begin
        btb_d[updIdx].ctr = ctr_e'(ctrNext);
        if (upd_taken) begin
          btb_d[updIdx].target = upd_target;
        end
      end else if (upd_taken) begin
        btb_d[updIdx].valid  = 1'b1;
        btb_d[updIdx].tag    = updTag;
        btb_d[updIdx].target = upd_target;
        btb_d[updIdx].ctr    = CTR_ALLOC;
      end
    end
  end

  always_comb begin
    mispredictCnt_d = mispredictCnt_q;
    if (updMispredict && (mispredictCnt_q != 32'hFFFF_FFFF)) begin
      mispredictCnt_d = mispredictCnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: 32'h0, ctr: CTR_RESET};
      end
      mispredictCnt_q <= 32'h0;
    end else begin
      btb_q           <= btb_d;
      mispredictCnt_q <= mispredictCnt_d;
    end
  end

  assign mispredict_cnt = mispredictCnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: training, saturation, aliasing,
// same-cycle lookup/update, flush and asynchronous reset.
module tb_branch_predict_unit;

  logic        clk;
  logic        rstn;
  logic [31:0] pc_i;
  logic        bpu_branch;
  logic [31:0] bpu_addr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush_i;
  logic [31:0] mispredict_cnt;

  int errors;
  int checks;

  branch_predict_unit #(.ENTRIES(16)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .pc_i           (pc_i),
    .bpu_branch     (bpu_branch),
    .bpu_addr       (bpu_addr),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .flush_i        (flush_i),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic uv,
                               input logic [31:0] upc, input logic taken,
                               input logic [31:0] tgt, input logic flush);
    pc_i       = pc;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = taken;
    upd_target = tgt;
    flush_i    = flush;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One training update at pc 0x100 followed by a lookup of the same pc.
  task automatic train100(input logic taken, input logic [31:0] tgt,
                          input string tag, input logic expBranch,
                          input logic [31:0] expAddr, input logic [31:0] expCnt);
    applyStimulus(32'h100, 1'b1, 32'h100, taken, tgt, 1'b0);
    tick();
    applyStimulus(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput({tag, "_branch"}, {31'h0, bpu_branch}, {31'h0, expBranch});
    checkOutput({tag, "_addr"}, bpu_addr, expAddr);
    checkOutput({tag, "_cnt"}, mispredict_cnt, expCnt);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rstn = 1'b0;
    applyStimulus(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("rst_branch", {31'h0, bpu_branch}, 32'h0);
    checkOutput("rst_addr", bpu_addr, 32'h0);
    checkOutput("rst_cnt", mispredict_cnt, 32'h0);
    tick();
    tick();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    checkOutput("idle_branch", {31'h0, bpu_branch}, 32'h0);
    checkOutput("idle_addr", bpu_addr, 32'h0);

    // Allocate 0x100 -> 0x140; the lookup in the same cycle sees the old miss.
    applyStimulus(32'h100, 1'b1, 32'h100, 1'b1, 32'h140, 1'b0);
    checkOutput("alloc_same_cycle", {31'h0, bpu_branch}, 32'h0);
    tick();
    applyStimulus(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("alloc_branch", {31'h0, bpu_branch}, 32'h1);
    checkOutput("alloc_addr", bpu_addr, 32'h140);
    checkOutput("alloc_cnt", mispredict_cnt, 32'd1);

    // WT -> WNT (mispredict), WNT -> SNT (no mispredict)
    train100(1'b0, 32'h999, "nt1", 1'b0, 32'h140, 32'd2);
    train100(1'b0, 32'h999, "nt2", 1'b0, 32'h140, 32'd2);
    // SNT -> WNT keeps not-taken, proving the previous step reached SNT
    train100(1'b1, 32'h180, "t1", 1'b0, 32'h180, 32'd3);
    train100(1'b1, 32'h180, "t2", 1'b1, 32'h180, 32'd4);
    train100(1'b1, 32'h180, "t3", 1'b1, 32'h180, 32'd4);
    train100(1'b1, 32'h180, "t4", 1'b1, 32'h180, 32'd4);
    // ST saturated, so one not-taken leaves WT and still predicts taken
    train100(1'b0, 32'h0, "nt_sat", 1'b1, 32'h180, 32'd5);

    // 0x500 aliases index 0 with a different tag and evicts 0x100
    applyStimulus(32'h100, 1'b1, 32'h500, 1'b1, 32'h540, 1'b0);
    tick();
    applyStimulus(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("alias_old_branch", {31'h0, bpu_branch}, 32'h0);
    checkOutput("alias_old_addr", bpu_addr, 32'h0);
    applyStimulus(32'h500, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("alias_new_branch", {31'h0, bpu_branch}, 32'h1);
    checkOutput("alias_new_addr", bpu_addr, 32'h540);
    checkOutput("alias_cnt", mispredict_cnt, 32'd6);

    // Same-cycle lookup and allocate at 0x200
    applyStimulus(32'h200, 1'b1, 32'h200, 1'b1, 32'h280, 1'b0);
    checkOutput("same_cyc_branch", {31'h0, bpu_branch}, 32'h0);
    checkOutput("same_cyc_addr", bpu_addr, 32'h0);
    tick();
    applyStimulus(32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("next_cyc_branch", {31'h0, bpu_branch}, 32'h1);
    checkOutput("next_cyc_addr", bpu_addr, 32'h280);
    checkOutput("next_cyc_cnt", mispredict_cnt, 32'd7);

    // Miss + not-taken changes nothing and is not a mispredict
    applyStimulus(32'h200, 1'b1, 32'h600, 1'b0, 32'h640, 1'b0);
    tick();
    applyStimulus(32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("miss_nt_branch", {31'h0, bpu_branch}, 32'h1);
    checkOutput("miss_nt_addr", bpu_addr, 32'h280);
    checkOutput("miss_nt_cnt", mispredict_cnt, 32'd7);

    // Flush beats the taken update at 0x300; the miss still counts
    applyStimulus(32'h300, 1'b1, 32'h300, 1'b1, 32'h340, 1'b1);
    tick();
    applyStimulus(32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("flush_300_branch", {31'h0, bpu_branch}, 32'h0);
    checkOutput("flush_300_addr", bpu_addr, 32'h0);
    checkOutput("flush_cnt", mispredict_cnt, 32'd8);
    applyStimulus(32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("flush_200_branch", {31'h0, bpu_branch}, 32'h0);

    // Re-allocation after flush starts again at WT
    applyStimulus(32'h200, 1'b1, 32'h200, 1'b1, 32'h2A0, 1'b0);
    tick();
    applyStimulus(32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("realloc_branch", {31'h0, bpu_branch}, 32'h1);
    checkOutput("realloc_addr", bpu_addr, 32'h2A0);
    checkOutput("realloc_cnt", mispredict_cnt, 32'd9);

    // Asynchronous reset mid-update discards the pending allocation
    applyStimulus(32'h300, 1'b1, 32'h300, 1'b1, 32'h340, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_branch", {31'h0, bpu_branch}, 32'h0);
    checkOutput("async_rst_cnt", mispredict_cnt, 32'h0);
    tick();
    applyStimulus(32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    checkOutput("post_rst_branch", {31'h0, bpu_branch}, 32'h0);
    checkOutput("post_rst_addr", bpu_addr, 32'h0);
    checkOutput("post_rst_cnt", mispredict_cnt, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. It sits beside the instruction-fetch stage: each cycle it looks up the current fetch PC and, on a predicted-taken hit, tells fetch to redirect to the stored target. The execute stage writes back resolved conditional-branch outcomes to train the table.

## Interface
Parameters:
- ENTRIES, 16: number of BTB entries; power of two, 4..64.
- IDX_W, $clog2(ENTRIES): index width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- pc_i  in  32  current fetch PC (word aligned).
- bpu_branch  out  1  predict taken; fetch loads bpu_addr this cycle.
- bpu_addr  out  32  predicted target.
- upd_valid  in  1  resolved conditional branch present this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  32  actual target (pc+imm).
- flush_i  in  1  invalidate all entries.
- mispredict_cnt  out  32  count of updates whose stored prediction disagreed with upd_taken.

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- Entry fields: valid, tag, target[31:0], ctr[1:0].
- Lookup is combinational on pc_i:
  - hit = valid & (tag match).
  - bpu_branch = hit & ctr[1].
  - bpu_addr = entry target when hit, else 0.
- Update on upd_valid, using the entry at upd_pc's index:
  - Hit, taken: ctr increments, saturating at 3; target <= upd_target.
  - Hit, not taken: ctr decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate (valid=1, tag, target, ctr=2'b10), overwriting any occupant.
  - Miss, not taken: no change.
- Mispredict: the old prediction (hit & ctr[1]) differs from upd_taken. mispredict_cnt increments and saturates at 32'hFFFFFFFF.
- flush_i clears all valid bits next edge.
  - ctr and target are left unchanged.
  - mispredict_cnt is not cleared.
- flush_i and upd_valid in the same cycle: flush wins and no allocation occurs. The mispredict count still updates.

## Timing
- Lookup latency 0: bpu_branch and bpu_addr are valid in the same cycle as pc_i.
- Update writes on the rising edge and is visible to lookups from the next cycle.
- Same-index lookup and update in one cycle: the lookup returns pre-update contents.
- Reset (asynchronous):
  - All valid=0, ctr=2'b01, target=0, mispredict_cnt=0.
  - Hence bpu_branch=0 and bpu_addr=0 immediately.
- Reset mid-update: the update is discarded.
- No handshake: updates are accepted every cycle with no back-pressure.
- Only one update per cycle.

## Structure
- Shared package bpu_pkg:
  - Counter encodings SNT=0, WNT=1, WT=2, ST=3.
  - Allocation value WT; reset value WNT.
  - btb_entry_t struct (valid, tag, target, ctr).
- Sub-module bpu_sat_ctr: 2-bit saturating counter next-state logic.
  - Inputs: ctr, taken. Output: ctr_next.
  - Instantiated once, in the update path.
- Table held in flops (not SRAM), because of the asynchronous reset and zero-latency read.

## Test plan
- Reset, then pc_i=0x100 → bpu_branch=0, bpu_addr=0; mispredict_cnt=0.
- Update upd_pc=0x100, taken, target=0x140; next cycle pc_i=0x100 → bpu_branch=1, bpu_addr=0x140, ctr=WT, mispredict_cnt=1.
- Two not-taken updates at 0x100:
  - After the first → ctr=WNT, bpu_branch=0.
  - After the second → ctr=SNT.
  - mispredict_cnt goes 1→2 (first update only).
- Aliasing, ENTRIES=16:
  - Allocate 0x100, then a taken update at 0x500 (same index, different tag).
  - Lookup of 0x100 → miss; lookup of 0x500 → hit with its own target.
- Same-cycle lookup and allocate at 0x200 → bpu_branch=0 that cycle and 1 the next.
- flush_i and taken update at 0x300 together → no hit on 0x300 afterwards; mispredict_cnt unchanged by the flush.
